// File: rtl/hol_round_controller_if.sv
// Player-facing bus of the Higher-or-Lower round controller: button pulses in,
// game state and score out towards the renderer.
interface hol_round_controller_if;
  logic       start_pulse;
  logic       higher_pulse;
  logic       lower_pulse;
  logic [2:0] state;
  logic [3:0] current_card;
  logic [3:0] next_card;
  logic       card_visible;
  logic [6:0] score;
  logic [6:0] high_score;
  logic       result_valid;
  logic       result_correct;

  // Button side: drives the pulses and watches the game.
  modport master (
    output start_pulse, higher_pulse, lower_pulse,
    input  state, current_card, next_card, card_visible,
    input  score, high_score, result_valid, result_correct
  );

  // Controller side.
  modport slave (
    input  start_pulse, higher_pulse, lower_pulse,
    output state, current_card, next_card, card_visible,
    output score, high_score, result_valid, result_correct
  );
endinterface

// File: rtl/hol_round_controller.sv
// Higher-or-Lower round controller: deals cards from a free-running LFSR,
// times the reveal, judges each guess and keeps score / high score.
module hol_round_controller #(
  parameter int unsigned REVEAL_CYCLES = 100000000,
  parameter int unsigned SCORE_MAX     = 99,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hol_round_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DEAL       = 3'd1,
    S_WAIT_GUESS = 3'd2,
    S_REVEAL     = 3'd3,
    S_GAME_OVER  = 3'd4
  } state_e;

  localparam int unsigned TIMER_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(REVEAL_CYCLES - 1);
  localparam logic [6:0] SCORE_CAP = 7'(SCORE_MAX);

  state_e             state_q, state_d;
  logic [3:0]         cur_q, cur_d;
  logic [3:0]         next_q, next_d;
  logic [6:0]         score_q, score_d;
  logic [6:0]         high_q, high_d;
  logic               guess_higher_q, guess_higher_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               result_valid_q, result_valid_d;
  logic               result_correct_q, result_correct_d;
  logic [15:0]        lfsr_q;

  logic [3:0] draw;
  logic       tie;
  logic       guessed_right;
  logic       verdict;
  logic [6:0] score_inc;

  // Fibonacci LFSR (taps 16,14,13,11), free-running from reset onwards.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Map the low nibble onto a card rank 1..13, folding 13..15 back to 1..3.
  assign draw = (lfsr_q[3:0] < 4'd13) ? (lfsr_q[3:0] + 4'd1) : (lfsr_q[3:0] - 4'd12);

  // Verdict on the pending guess; a tie always counts as correct.
  assign tie           = (next_q == cur_q);
  assign guessed_right = guess_higher_q ? (next_q > cur_q) : (next_q < cur_q);
  assign verdict       = tie | guessed_right;
  assign score_inc     = (score_q >= SCORE_CAP) ? SCORE_CAP : (score_q + 7'd1);

  // Game state register and all datapath registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cur_q            <= '0;
      next_q           <= '0;
      score_q          <= '0;
      high_q           <= '0;
      guess_higher_q   <= 1'b0;
      timer_q          <= '0;
      result_valid_q   <= 1'b0;
      result_correct_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_q            <= cur_d;
      next_q           <= next_d;
      score_q          <= score_d;
      high_q           <= high_d;
      guess_higher_q   <= guess_higher_d;
      timer_q          <= timer_d;
      result_valid_q   <= result_valid_d;
      result_correct_q <= result_correct_d;
    end
  end

  // Next-state and next-register logic for the round sequence.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    cur_d            = cur_q;
    next_d           = next_q;
    score_d          = score_q;
    high_d           = high_q;
    guess_higher_d   = guess_higher_q;
    timer_d          = timer_q;
    result_valid_d   = 1'b0;
    result_correct_d = result_correct_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_pulse) state_d = S_DEAL;
      end
      S_DEAL: begin
        cur_d   = draw;
        score_d = '0;
        state_d = S_WAIT_GUESS;
      end
      S_WAIT_GUESS: begin
        // Only an unambiguous single guess is accepted.
        if (bus.higher_pulse ^ bus.lower_pulse) begin
          guess_higher_d = bus.higher_pulse;
          next_d         = draw;
          timer_d        = TIMER_LOAD;
          state_d        = S_REVEAL;
        end
      end
      S_REVEAL: begin
        if (timer_q == '0) begin
          result_valid_d   = 1'b1;
          result_correct_d = verdict;
          if (verdict) begin
            if (!tie) score_d = score_inc;
            cur_d   = next_q;
            state_d = S_WAIT_GUESS;
          end else begin
            if (score_q > high_q) high_d = score_q;
            state_d = S_GAME_OVER;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_GAME_OVER: begin
        if (bus.start_pulse) state_d = S_DEAL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.state          = state_q;
  assign bus.current_card   = cur_q;
  assign bus.next_card      = next_q;
  assign bus.card_visible   = (state_q == S_REVEAL);
  assign bus.score          = score_q;
  assign bus.high_score     = high_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_correct = result_correct_q;

endmodule

// File: tb/tb_hol_round_controller.sv
// Bench for hol_round_controller: transaction-level game model with a
// reference LFSR, randomized guesses and randomized ignored pulses.
module tb_hol_round_controller;
  localparam int unsigned RC   = 4;
  localparam int unsigned SMAX = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hol_round_controller_if bus();

  hol_round_controller #(
    .REVEAL_CYCLES(RC),
    .SCORE_MAX    (SMAX),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Game-level reference model.
  logic [15:0] m_lfsr;
  int m_state, m_cur, m_next, m_score, m_high, m_rc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int card_of(input logic [15:0] l);
    return (int'(l) % 16) % 13 + 1;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic clk_step();
    @(posedge clk);
    #1;
    if (!rst_n) m_lfsr = SEED;
    else        m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic clear_pulses();
    bus.start_pulse  = 1'b0;
    bus.higher_pulse = 1'b0;
    bus.lower_pulse  = 1'b0;
  endtask

  task automatic reset_model();
    m_state = 0; m_cur = 0; m_next = 0; m_score = 0; m_high = 0; m_rc = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_state"}, bus.state, m_state);
    check({tag, "_cur"},   bus.current_card, m_cur);
    check({tag, "_next"},  bus.next_card, m_next);
    check({tag, "_score"}, bus.score, m_score);
    check({tag, "_high"},  bus.high_score, m_high);
  endtask

  // Start pulse from IDLE or GAME_OVER, then the DEAL cycle.
  task automatic press_start();
    int d;
    bus.start_pulse = 1'b1;
    clk_step();
    clear_pulses();
    check("start_deal", bus.state, 1);
    d = card_of(m_lfsr);
    clk_step();
    m_state = 2; m_cur = d; m_score = 0;
    check_all("dealt");
    check("dealt_rv", bus.result_valid, 0);
  endtask

  // One WAIT_GUESS cycle with an input mix that must be ignored.
  task automatic idle_wait();
    int r;
    r = $urandom_range(2);
    if (r == 1) begin bus.higher_pulse = 1'b1; bus.lower_pulse = 1'b1; end
    if (r == 2) bus.start_pulse = 1'b1;
    clk_step();
    clear_pulses();
    check("wait_hold_state", bus.state, 2);
    check("wait_hold_score", bus.score, m_score);
  endtask

  // Idle in WAIT_GUESS until the upcoming draw is a tie (want_tie) or not.
  task automatic wait_draw(input bit want_tie);
    int guard = 0;
    while (((card_of(m_lfsr) == m_cur) != want_tie) && guard < 1000) begin
      idle_wait();
      guard++;
    end
    check("draw_found", 32'(guard < 1000), 1);
  endtask

  // Full guess transaction: entry, timed reveal with noise, verdict.
  task automatic do_guess(input bit hi);
    int d, vis, guard;
    bit tie, ok;
    d = card_of(m_lfsr);
    bus.higher_pulse = hi;
    bus.lower_pulse  = !hi;
    clk_step();
    clear_pulses();
    m_next = d;
    check("reveal_enter", bus.state, 3);
    check("reveal_next", bus.next_card, d);
    check("reveal_visible", bus.card_visible, 1);
    vis = 1;
    guard = 0;
    while (bus.state == 3 && guard < 20) begin
      bus.start_pulse  = 1'($urandom_range(1));
      bus.higher_pulse = 1'($urandom_range(1));
      bus.lower_pulse  = 1'($urandom_range(1));
      clk_step();
      clear_pulses();
      guard++;
      if (bus.state == 3) begin
        vis++;
        check("reveal_no_rv", bus.result_valid, 0);
        check("reveal_score", bus.score, m_score);
      end
    end
    check("reveal_len", vis, RC);
    tie = (d == m_cur);
    ok  = tie || (hi ? (d > m_cur) : (d < m_cur));
    if (ok) begin
      if (!tie) m_score = min_int(m_score + 1, SMAX);
      m_cur = d;
      m_state = 2;
    end else begin
      if (m_score > m_high) m_high = m_score;
      m_state = 4;
    end
    m_rc = ok;
    check("verdict_rv", bus.result_valid, 1);
    check("verdict_rc", bus.result_correct, m_rc);
    check("verdict_visible", bus.card_visible, 0);
    check_all("verdict");
    clk_step();
    check("after_rv", bus.result_valid, 0);
    check("after_rc_held", bus.result_correct, m_rc);
    check_all("after");
  endtask

  task automatic win();
    wait_draw(1'b0);
    do_guess(card_of(m_lfsr) > m_cur);
  endtask

  task automatic lose();
    wait_draw(1'b0);
    do_guess(card_of(m_lfsr) < m_cur);
  endtask

  // GAME_OVER cycles with higher/lower noise: nothing may move.
  task automatic game_over_hold(input int n);
    for (int i = 0; i < n; i++) begin
      bus.higher_pulse = 1'($urandom_range(1));
      bus.lower_pulse  = 1'($urandom_range(1));
      clk_step();
      clear_pulses();
      check_all("gameover_hold");
      check("gameover_rv", bus.result_valid, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_walk[4] = '{1, 2, 3, 3};
    clear_pulses();
    reset_model();
    m_lfsr = SEED;

    // Reset for 3 edges.
    rst_n = 1'b0;
    repeat (3) clk_step();
    check_all("reset");
    check("reset_rv", bus.result_valid, 0);
    check("reset_rc", bus.result_correct, 0);
    check("reset_visible", bus.card_visible, 0);
    rst_n = 1'b1;

    // Guesses in IDLE are dropped.
    for (int i = 0; i < 5; i++) begin
      bus.higher_pulse = 1'($urandom_range(1));
      bus.lower_pulse  = 1'($urandom_range(1));
      clk_step();
      clear_pulses();
      check("idle_hold", bus.state, 0);
      check("idle_rv", bus.result_valid, 0);
    end

    // Two wins then a loss: high score captures 2.
    press_start();
    win();
    check("walk_a", bus.score, 1);
    win();
    check("walk_b", bus.score, 2);
    lose();
    check("lose_state", bus.state, 4);
    check("lose_score", bus.score, 2);
    check("lose_high", bus.high_score, 2);
    check("lose_rc", bus.result_correct, 0);
    game_over_hold(3);
    press_start();
    check("restart_score", bus.score, 0);
    check("restart_high", bus.high_score, 2);

    // Saturation at SCORE_MAX=3, then a tie.
    for (int i = 0; i < 4; i++) begin
      win();
      check("sat_walk", bus.score, exp_walk[i]);
    end
    wait_draw(1'b1);
    do_guess(1'($urandom_range(1)));
    check("tie_score", bus.score, 3);
    check("tie_rc", bus.result_correct, 1);

    // Randomized play.
    for (int i = 0; i < 30; i++) begin
      if (m_state == 4) begin
        game_over_hold(1);
        press_start();
      end
      repeat ($urandom_range(3)) idle_wait();
      do_guess(1'($urandom_range(1)));
    end

    // Reset during the second REVEAL cycle.
    if (m_state == 4) press_start();
    if (m_high == 0) lose();
    if (m_state == 4) press_start();
    bus.higher_pulse = 1'b1;
    clk_step();
    clear_pulses();
    check("midrst_reveal", bus.state, 3);
    clk_step();
    check("midrst_reveal2", bus.state, 3);
    rst_n = 1'b0;
    clk_step();
    reset_model();
    check_all("midrst");
    check("midrst_visible", bus.card_visible, 0);
    check("midrst_rv", bus.result_valid, 0);
    rst_n = 1'b1;

    // Deal again from the reseeded LFSR.
    press_start();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hol_round_controller.md
Name: hol_round_controller

Overview:
- Game-sequencing FSM for the Higher-or-Lower design.
- Consumes the one-cycle button pulses from the per-button pulse generators (start, higher, lower) and deals cards from a free-running LFSR.
- Times the reveal phase, judges each guess, and maintains the score and high score for the VGA renderer.

Parameters:
- REVEAL_CYCLES, 100000000, cycles the drawn card stays in the REVEAL state (1 s at 100 MHz); benches override to 4.
- SCORE_MAX, 99, score saturation value; must fit in 7 bits.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start_pulse  input  1  one-cycle pulse, start/restart game.
- higher_pulse  input  1  one-cycle pulse, guess "higher".
- lower_pulse  input  1  one-cycle pulse, guess "lower".
- state  output  3  FSM state: IDLE=0, DEAL=1, WAIT_GUESS=2, REVEAL=3, GAME_OVER=4.
- current_card  output  4  card in play, 1..13 (0 before first deal).
- next_card  output  4  drawn card, 1..13 (0 until first draw).
- card_visible  output  1  high while state==REVEAL.
- score  output  7  current run score.
- high_score  output  7  best score since reset.
- result_valid  output  1  one-cycle pulse on REVEAL exit.
- result_correct  output  1  verdict, held until the next result_valid.

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst_n, and applies on any clk edge with rst_n==0.
- Reset values: state=IDLE, current_card=0, next_card=0, score=0, high_score=0, result_valid=0, result_correct=0, lfsr=LFSR_SEED, timer=0.
- Reset mid-operation (including REVEAL) returns every register to these values; high_score is also cleared.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11: new bit = l[15]^l[13]^l[12]^l[10], shifted into bit 0.
  - Advances every cycle after reset, regardless of state.
- Draw value d = l[3:0]+1 if l[3:0]<13, else l[3:0]-12. Use the current (pre-advance) lfsr value.
- IDLE: start_pulse -> DEAL. Higher and lower pulses are ignored.
- DEAL, one cycle: current_card<=d, score<=0, next_card unchanged -> WAIT_GUESS.
- WAIT_GUESS:
  - Exactly one of higher_pulse/lower_pulse: latch the guess, next_card<=d, timer<=REVEAL_CYCLES-1 -> REVEAL.
  - Both pulses in the same cycle: ignored, stay.
  - start_pulse: ignored.
- REVEAL:
  - Lasts exactly REVEAL_CYCLES cycles; the timer decrements and exit happens on the cycle timer==0.
  - All pulses, including start, are ignored.
  - On exit, evaluate:
    - correct = (guess higher and next_card>current_card) or (guess lower and next_card<current_card).
    - tie (next_card==current_card) = correct, with no score change.
  - Correct non-tie: score<=min(score+1,SCORE_MAX); current_card<=next_card -> WAIT_GUESS.
  - Tie: current_card<=next_card -> WAIT_GUESS.
  - Wrong: -> GAME_OVER; if score>high_score, high_score<=score.
  - On the exit edge: result_valid=1 for one cycle, result_correct registered with the verdict.
- GAME_OVER: score and cards hold; start_pulse -> DEAL. Higher and lower pulses are ignored.
- Latency: a pulse sampled at edge t produces the new state/registers visible after edge t. The verdict is visible REVEAL_CYCLES edges after REVEAL entry.
- Pulses arriving in non-accepting states are dropped, not queued.

Test Plan:
- Reset: hold rst_n=0 for 3 edges -> state=0, score=0, high_score=0, cards=0, result_valid=0. Release, then compare the lfsr-derived draws against a bench LFSR model seeded 16'hACE1.
- Deal plus correct guess (REVEAL_CYCLES=4): start_pulse -> DEAL for 1 cycle, then WAIT_GUESS with current_card = model draw. Issue the pulse the model predicts correct -> card_visible=1 for exactly 4 cycles, result_valid pulse, result_correct=1, score=1, current_card=previous next_card.
- Wrong guess: issue the losing pulse -> GAME_OVER, result_correct=0. high_score becomes the prior score (e.g. 2), score holds 2. Then start_pulse -> DEAL, score=0, high_score stays 2.
- Ignored inputs:
  - higher_pulse and lower_pulse together in WAIT_GUESS -> state stays 2.
  - Pulses during REVEAL and IDLE -> no state/score change, no result_valid.
- Saturation (SCORE_MAX=3): four correct guesses in a row -> score reads 1, 2, 3, 3. A tie draw -> score unchanged, result_correct=1.
- Reset mid-REVEAL: rst_n=0 on the 2nd REVEAL cycle -> next edge state=0, card_visible=0, score=0, high_score=0, no result_valid.
